// File: rtl/mwadd_pkg.sv
// -----------------------------------------------------------------------------
// mwadd_pkg
// Shared types and helpers for the multi-word add sequencer.
//
// Contents:
//   mwadd_state_t : sequencer state (IDLE = expecting word 0, BUSY = mid-operation)
//   cnt_width()   : beat-counter width for a given WORDS, never less than 1 bit
// -----------------------------------------------------------------------------
package mwadd_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mwadd_state_t;

    // A WORDS=1 build still needs a 1-bit counter so the vector is legal.
    function automatic int cnt_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/multiword_add_sequencer_if.sv
// -----------------------------------------------------------------------------
// multiword_add_sequencer_if
// Bundles the upstream beat handshake and the downstream sum-word handshake
// of the multi-word add sequencer.
//
// Parameters:
//   N : word width in bits
//
// Signals:
//   in_valid / in_ready   : upstream beat handshake
//   in_a, in_b            : operand words of the current significance
//   cin_init              : carry-in for word 0 of an operation
//   out_valid / out_ready : downstream handshake
//   out_sum, out_cout     : registered sum word and its carry-out
//   out_last              : most significant word of the operation
//   out_ovf               : two's-complement overflow flag on the last word
//                           (present only when MWADD_OVERFLOW_FLAG_EN is defined)
//
// Modports:
//   slave  : the sequencer's view
//   master : the view of whoever drives beats in and takes sums out
// -----------------------------------------------------------------------------
interface multiword_add_sequencer_if #(
    parameter int N = 32
);

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_a;
    logic [N-1:0] in_b;
    logic         cin_init;

    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_sum;
    logic         out_cout;
    logic         out_last;
`ifdef MWADD_OVERFLOW_FLAG_EN
    logic         out_ovf;

    modport slave (
        input  in_valid, in_a, in_b, cin_init, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_last, out_ovf
    );

    modport master (
        output in_valid, in_a, in_b, cin_init, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_last, out_ovf
    );
`else
    modport slave (
        input  in_valid, in_a, in_b, cin_init, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_last
    );

    modport master (
        output in_valid, in_a, in_b, cin_init, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_last
    );
`endif

endinterface

// File: rtl/n_bit_pg_carry_ripple.sv
// -----------------------------------------------------------------------------
// n_bit_pg_carry_ripple
// Combinational N-bit adder built from per-bit propagate/generate terms with
// a rippled carry chain.
//
// Parameters:
//   N : operand width in bits
//
// Ports:
//   a_i    in  N  operand A
//   b_i    in  N  operand B
//   cin_i  in  1  carry into bit 0
//   sum_o  out N  A + B + cin, low N bits
//   cout_o out 1  carry out of bit N-1
// -----------------------------------------------------------------------------
module n_bit_pg_carry_ripple #(
    parameter int N = 32
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         cin_i,
    output logic [N-1:0] sum_o,
    output logic         cout_o
);

    logic [N-1:0] prop;
    logic [N-1:0] gen;
    logic [N:0]   carry;

    assign prop = a_i ^ b_i;
    assign gen  = a_i & b_i;

    // carry[i] is the carry into bit i; carry[N] leaves the word.
    always_comb begin
        carry[0] = cin_i;
        for (int i = 0; i < N; i++) begin
            carry[i+1] = gen[i] | (prop[i] & carry[i]);
        end
    end

    assign sum_o  = prop ^ carry[N-1:0];
    assign cout_o = carry[N];

endmodule

// File: rtl/multiword_add_sequencer.sv
// -----------------------------------------------------------------------------
// multiword_add_sequencer
// Adds two WORDS x N-bit operands one N-bit word per accepted beat, least
// significant word first. Each beat's carry-out is held in a carry register
// and fed to the next beat; word 0 takes its carry from cin_init instead.
// Every sum word is registered behind a valid/ready output stage.
//
// Parameters:
//   N     : word width in bits (passed to the adder)
//   WORDS : words per operation, >= 1
//
// Ports:
//   clk   in  1  rising-edge clock
//   reset in  1  synchronous, active-high reset
//   mw_if        multiword_add_sequencer_if.slave
//                  in_valid/in_ready/in_a/in_b/cin_init  : upstream beats
//                  out_valid/out_ready/out_sum/out_cout/out_last : sum words
//
// Optional build macro:
//   MWADD_OVERFLOW_FLAG_EN : adds mw_if.out_ovf, the two's-complement overflow
//                            of the full-width operation, flagged on the last
//                            word and 0 on all other words.
//
// The output stage is a single register with pass-through ready: a new beat
// can be taken whenever the register is empty or is being drained in the same
// cycle, so back-to-back beats flow without bubbles, and a stalled output
// stalls the input.
// -----------------------------------------------------------------------------
module multiword_add_sequencer
    import mwadd_pkg::*;
#(
    parameter int N     = 32,
    parameter int WORDS = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    multiword_add_sequencer_if.slave       mw_if
);

    localparam int             CW       = cnt_width(WORDS);
    localparam logic [CW-1:0]  LAST_CNT = CW'(WORDS - 1);
    localparam logic [CW-1:0]  ONE_CNT  = CW'(1);

    // Sequencing state
    mwadd_state_t  state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          carry_q, carry_d;

    // Output register
    logic          valid_q, valid_d;
    logic [N-1:0]  sum_q,   sum_d;
    logic          cout_q,  cout_d;
    logic          last_q,  last_d;
`ifdef MWADD_OVERFLOW_FLAG_EN
    logic          ovf_q,   ovf_d;
`endif

    // Handshake and datapath
    logic          in_ready;
    logic          accept;
    logic          last_beat;
    logic          adder_cin;
    logic [N-1:0]  adder_sum;
    logic          adder_cout;

    assign in_ready = ~valid_q | mw_if.out_ready;
    assign accept   = mw_if.in_valid & in_ready;

    // Word 0 starts from the caller's carry; later words chain the previous
    // carry-out, so cin_init is ignored once an operation is under way.
    assign adder_cin = (state_q == IDLE) ? mw_if.cin_init : carry_q;

    // The beat being offered closes the operation: in IDLE only when an
    // operation is a single word, in BUSY when the counter reaches the top.
    assign last_beat = (state_q == IDLE) ? (WORDS == 1) : (cnt_q == LAST_CNT);

    n_bit_pg_carry_ripple #(
        .N (N)
    ) u_adder (
        .a_i    (mw_if.in_a),
        .b_i    (mw_if.in_b),
        .cin_i  (adder_cin),
        .sum_o  (adder_sum),
        .cout_o (adder_cout)
    );

    always_comb begin
        // NOTE: every variable gets a hold value before any branch, so no
        // path leaves one unassigned and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        valid_d = valid_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        last_d  = last_q;
`ifdef MWADD_OVERFLOW_FLAG_EN
        ovf_d   = ovf_q;
`endif

        if (accept) begin
            // A new word replaces the register whether or not the previous
            // one is leaving this cycle; in_ready already guarantees it is.
            valid_d = 1'b1;
            sum_d   = adder_sum;
            cout_d  = adder_cout;
            last_d  = last_beat;
`ifdef MWADD_OVERFLOW_FLAG_EN
            // Operands share a sign bit but the sum's sign differs.
            ovf_d   = last_beat
                    & (mw_if.in_a[N-1] == mw_if.in_b[N-1])
                    & (adder_sum[N-1] != mw_if.in_a[N-1]);
`endif
            if (last_beat) begin
                // Carry is dropped here; the final carry travels on out_cout.
                state_d = IDLE;
                cnt_d   = '0;
                carry_d = 1'b0;
            end else begin
                state_d = BUSY;
                cnt_d   = cnt_q + ONE_CNT;
                carry_d = adder_cout;
            end
        end else if (mw_if.out_ready) begin
            // Output drained with nothing new behind it.
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every
        // register samples its _d value from before this edge.
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            valid_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            last_q  <= 1'b0;
`ifdef MWADD_OVERFLOW_FLAG_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            valid_q <= valid_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            last_q  <= last_d;
`ifdef MWADD_OVERFLOW_FLAG_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign mw_if.in_ready  = in_ready;
    assign mw_if.out_valid = valid_q;
    assign mw_if.out_sum   = sum_q;
    assign mw_if.out_cout  = cout_q;
    assign mw_if.out_last  = last_q;
`ifdef MWADD_OVERFLOW_FLAG_EN
    assign mw_if.out_ovf   = ovf_q;
`endif

endmodule
